// File: rtl/crypto_job_dispatcher_pkg.sv
// Shared widths, job record and FSM encoding for the crypto job dispatcher.
// No logic, no latency.
// No flow control.
package crypto_job_dispatcher_pkg;

    localparam int ADDR_W  = 19;
    localparam int MEM_AW  = 10;
    localparam int DATA_W  = 19;
    localparam int QDEPTH  = 4;
    localparam int TIMEOUT = 64;
    localparam int WCNT_W  = $clog2(TIMEOUT);

    localparam logic [2:0] ACCEL_TAG = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETIRE = 2'd3
    } disp_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
    } job_t;

    // Only jobs whose source lies in the accelerator region may be queued.
    function automatic logic tag_ok(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: 3] == ACCEL_TAG;
    endfunction

endpackage

// File: rtl/crypto_job_dispatcher_if.sv
// CPU command, accelerator and shared memory-port signals of the dispatcher.
// Pure wiring, no latency.
// cmd_valid/cmd_ready handshake; cpu_stall tells the CPU to retry.
interface crypto_job_dispatcher_if;
    import crypto_job_dispatcher_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_src;
    logic [ADDR_W-1:0] cmd_dst;

    logic              acc_start;
    logic [ADDR_W-1:0] acc_input_addr;
    logic [ADDR_W-1:0] acc_result_addr;
    logic              acc_done;
    logic [MEM_AW-1:0] acc_mem_addr;
    logic              acc_mem_write;
    logic [DATA_W-1:0] acc_mem_wdata;

    logic              cpu_mem_req;
    logic [MEM_AW-1:0] cpu_mem_addr;
    logic              cpu_mem_write;
    logic [DATA_W-1:0] cpu_mem_wdata;
    logic              cpu_stall;

    logic [MEM_AW-1:0] mem_addr;
    logic              mem_write;
    logic [DATA_W-1:0] mem_wdata;

    logic              busy;
    logic [7:0]        jobs_done;
    logic              err_badtag;
    logic              err_timeout;
    logic              err_clr;

    // Dispatcher side.
    modport slave (
        input  cmd_valid, cmd_src, cmd_dst,
        input  acc_done, acc_mem_addr, acc_mem_write, acc_mem_wdata,
        input  cpu_mem_req, cpu_mem_addr, cpu_mem_write, cpu_mem_wdata,
        input  err_clr,
        output cmd_ready, acc_start, acc_input_addr, acc_result_addr,
        output cpu_stall, mem_addr, mem_write, mem_wdata,
        output busy, jobs_done, err_badtag, err_timeout
    );

    // CPU / accelerator / SoC side.
    modport master (
        output cmd_valid, cmd_src, cmd_dst,
        output acc_done, acc_mem_addr, acc_mem_write, acc_mem_wdata,
        output cpu_mem_req, cpu_mem_addr, cpu_mem_write, cpu_mem_wdata,
        output err_clr,
        input  cmd_ready, acc_start, acc_input_addr, acc_result_addr,
        input  cpu_stall, mem_addr, mem_write, mem_wdata,
        input  busy, jobs_done, err_badtag, err_timeout
    );

endinterface

// File: rtl/crypto_job_dispatcher_cmd_fifo.sv
// Synchronous FIFO holding queued jobs; head is shown combinationally.
// Write visible at head one cycle after push.
// full_o blocks further pushes; push on full and pop on empty are ignored.
module crypto_job_dispatcher_cmd_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic          push_ok;
    logic          pop_ok;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    // Pointer advance.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok) wr_d = wr_q + PW'(1);
        if (pop_ok)  rd_d = rd_q + PW'(1);
    end

    // Pointer registers, flushed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/crypto_job_dispatcher.sv
// Queues CPU jobs, launches them one at a time on the accelerator, arbitrates the data-memory port.
// Launch 2 cycles after push into an idle queue; retire 2 cycles after acc_done.
// cmd_ready drops while the queue (including the job in flight) is full; CPU memory access stalls while the accelerator owns memory.
module crypto_job_dispatcher
    import crypto_job_dispatcher_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    crypto_job_dispatcher_if.slave  bus
);

    disp_state_e       state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [7:0]        jobs_q, jobs_d;
    logic              err_badtag_q, err_badtag_d;
    logic              err_timeout_q, err_timeout_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              badtag_set;
    logic              timeout_hit;
    logic              start;
    logic              owner_acc;
    job_t              head;
    job_t              new_job;

    // A job stays in the queue while in flight; it is popped on retire or abort.
    assign new_job    = '{src: bus.cmd_src, dst: bus.cmd_dst};
    assign fifo_push  = bus.cmd_valid & ~fifo_full & tag_ok(bus.cmd_src);
    assign badtag_set = bus.cmd_valid & ~fifo_full & ~tag_ok(bus.cmd_src);

    crypto_job_dispatcher_cmd_fifo #(
        .W     ($bits(job_t)),
        .DEPTH (QDEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (new_job),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Job sequencing: latch head, pulse start, wait for done or time out, retire.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        src_d       = src_q;
        dst_d       = dst_q;
        jobs_d      = jobs_q;
        fifo_pop    = 1'b0;
        timeout_hit = 1'b0;
        start       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_LAUNCH;
                    src_d   = head.src;
                    dst_d   = head.dst;
                end
            end
            ST_LAUNCH: begin
                start   = 1'b1;
                wcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.acc_done) begin
                    state_d = ST_RETIRE;
                end else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    fifo_pop    = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            ST_RETIRE: begin
                fifo_pop = 1'b1;
                jobs_d   = jobs_q + 8'd1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky errors: a new error in the same cycle as err_clr stays set.
    always_comb begin
        err_badtag_d  = bus.err_clr ? 1'b0 : err_badtag_q;
        err_timeout_d = bus.err_clr ? 1'b0 : err_timeout_q;
        if (badtag_set)  err_badtag_d  = 1'b1;
        if (timeout_hit) err_timeout_d = 1'b1;
    end

    // State, counters, latched job addresses and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wcnt_q        <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            jobs_q        <= '0;
            err_badtag_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            jobs_q        <= jobs_d;
            err_badtag_q  <= err_badtag_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Memory port: accelerator owns it from launch until done/abort, CPU otherwise.
    always_comb begin
        owner_acc = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
        if (owner_acc) begin
            bus.mem_addr  = bus.acc_mem_addr;
            bus.mem_write = bus.acc_mem_write;
            bus.mem_wdata = bus.acc_mem_wdata;
        end else begin
            bus.mem_addr  = bus.cpu_mem_addr;
            bus.mem_write = bus.cpu_mem_req & bus.cpu_mem_write;
            bus.mem_wdata = bus.cpu_mem_wdata;
        end
        bus.cpu_stall = bus.cpu_mem_req & owner_acc;
    end

    assign bus.cmd_ready       = ~fifo_full;
    assign bus.acc_start       = start;
    assign bus.acc_input_addr  = src_q;
    assign bus.acc_result_addr = dst_q;
    assign bus.busy            = (state_q != ST_IDLE) | ~fifo_empty;
    assign bus.jobs_done       = jobs_q;
    assign bus.err_badtag      = err_badtag_q;
    assign bus.err_timeout     = err_timeout_q;

endmodule

// File: tb/tb_crypto_job_dispatcher.sv
module tb_crypto_job_dispatcher;
    import crypto_job_dispatcher_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    crypto_job_dispatcher_if bus();

    crypto_job_dispatcher dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: accepted jobs in order, completion count, sticky errors.
    job_t exp_q[$];
    int   jobs_m     = 0;
    logic badtag_m   = 1'b0;
    logic timeout_m  = 1'b0;

    // Launch observer.
    job_t launch_log[$];
    int   launch_cyc[$];
    int   start_cnt  = 0;
    int   dbl_cnt    = 0;
    logic start_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.acc_start === 1'b1) begin
            launch_log.push_back('{src: bus.acc_input_addr, dst: bus.acc_result_addr});
            launch_cyc.push_back(cyc);
            start_cnt <= start_cnt + 1;
            if (start_prev) dbl_cnt <= dbl_cnt + 1;
        end
        start_prev <= (bus.acc_start === 1'b1);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    function automatic logic in_accel_region(input logic [18:0] a);
        return a[18:16] == 3'b110;
    endfunction

    task automatic push(input logic [18:0] s, input logic [18:0] d, input logic clr);
        int   w = 0;
        logic rdy;
        bus.cmd_valid = 1'b1;
        bus.cmd_src   = s;
        bus.cmd_dst   = d;
        bus.err_clr   = clr;
        while (bus.cmd_ready !== 1'b1 && w < 200) begin
            cycle();
            w++;
        end
        rdy = (bus.cmd_ready === 1'b1);
        check("push_ready", rdy, 1'b1);
        cycle();
        bus.cmd_valid = 1'b0;
        bus.err_clr   = 1'b0;
        if (rdy) begin
            if (clr) begin
                badtag_m  = 1'b0;
                timeout_m = 1'b0;
            end
            if (in_accel_region(s)) exp_q.push_back('{src: s, dst: d});
            else                    badtag_m = 1'b1;
        end
    endtask

    task automatic wait_launch(output logic ok);
        int w = 0;
        while (launch_log.size() == 0 && w < 200) begin
            cycle();
            w++;
        end
        ok = (launch_log.size() != 0);
        check("launch_seen", ok, 1'b1);
    endtask

    function automatic job_t model_head();
        job_t j = '0;
        if (exp_q.size() != 0) j = exp_q[0];
        return j;
    endfunction

    task automatic check_launch(output int lc);
        job_t got;
        job_t expj;
        got  = launch_log.pop_front();
        lc   = launch_cyc.pop_front();
        expj = model_head();
        check("launch_src", got.src, expj.src);
        check("launch_dst", got.dst, expj.dst);
    endtask

    task automatic retire_model();
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        jobs_m++;
    endtask

    task automatic check_after_retire();
        check("jobs_done", bus.jobs_done, 8'(jobs_m));
        check("busy", bus.busy, exp_q.size() != 0);
        check("cmd_ready", bus.cmd_ready, exp_q.size() < QDEPTH);
    endtask

    // Accelerator behaviour: answer the next launch with done after 'delay' WAIT cycles.
    task automatic serve(input int delay);
        logic ok;
        int   lc;
        wait_launch(ok);
        if (ok) begin
            check_launch(lc);
            repeat (delay) cycle();
            bus.acc_done = 1'b1;
            cycle();
            bus.acc_done = 1'b0;
            retire_model();
            cycle();
            check_after_retire();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_acc_start"}, bus.acc_start, 1'b0);
        check({tag, "_cpu_stall"}, bus.cpu_stall, 1'b0);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_mem_write"}, bus.mem_write, 1'b0);
        check({tag, "_err_badtag"}, bus.err_badtag, 1'b0);
        check({tag, "_err_timeout"}, bus.err_timeout, 1'b0);
        check({tag, "_jobs_done"}, bus.jobs_done, 8'd0);
        check({tag, "_in_addr"}, bus.acc_input_addr, 19'd0);
        check({tag, "_res_addr"}, bus.acc_result_addr, 19'd0);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
    endtask

    function automatic logic [18:0] rand_good_src();
        return {3'b110, 16'($urandom)};
    endfunction

    initial begin
        logic        ok;
        int          lc;
        int          w;
        int          s0;
        logic [2:0]  tg;
        job_t        jobs5[5];
        logic [9:0]  ca, aa;
        logic [18:0] cd, ad;
        logic        aw;

        rst               = 1'b1;
        bus.cmd_valid     = 1'b0;
        bus.cmd_src       = '0;
        bus.cmd_dst       = '0;
        bus.acc_done      = 1'b0;
        bus.acc_mem_addr  = '0;
        bus.acc_mem_write = 1'b0;
        bus.acc_mem_wdata = '0;
        bus.cpu_mem_req   = 1'b0;
        bus.cpu_mem_addr  = '0;
        bus.cpu_mem_write = 1'b0;
        bus.cpu_mem_wdata = '0;
        bus.err_clr       = 1'b0;

        // Step 1: reset values.
        repeat (3) cycle();
        check_reset_outputs("rst");
        rst = 1'b0;
        cycle();
        check_reset_outputs("post_rst");

        // Step 2: single job, done 21 cycles after start.
        s0 = start_cnt;
        push(19'h60010, 19'h60100, 1'b0);
        serve(20);
        check("single_start_count", start_cnt - s0, 1);

        // Step 3: five random jobs back to back; queue fills at four.
        for (int i = 0; i < 5; i++) jobs5[i] = '{src: rand_good_src(), dst: 19'($urandom)};
        for (int i = 0; i < 4; i++) push(jobs5[i].src, jobs5[i].dst, 1'b0);
        check("full_cmd_ready", bus.cmd_ready, exp_q.size() < QDEPTH);
        serve($urandom_range(0, 30));
        push(jobs5[4].src, jobs5[4].dst, 1'b0);
        for (int i = 0; i < 4; i++) serve($urandom_range(0, 30));

        // Step 4: bad region tag is consumed but never launched.
        tg = 3'($urandom_range(0, 6));
        if (tg == 3'b110) tg = 3'b111;
        push({tg, 16'($urandom)}, 19'($urandom), 1'b0);
        check("badtag_set", bus.err_badtag, badtag_m);
        repeat (10) cycle();
        check("badtag_no_launch", launch_log.size(), 0);
        check("badtag_idle", bus.busy, 1'b0);
        bus.err_clr = 1'b1;
        cycle();
        bus.err_clr = 1'b0;
        badtag_m  = 1'b0;
        timeout_m = 1'b0;
        check("badtag_clr", bus.err_badtag, badtag_m);
        tg = 3'($urandom_range(0, 5));
        push({tg, 16'($urandom)}, 19'($urandom), 1'b1);
        check("badtag_set_wins", bus.err_badtag, badtag_m);
        bus.err_clr = 1'b1;
        cycle();
        bus.err_clr = 1'b0;
        badtag_m = 1'b0;

        // Step 5: first job never completes; it is aborted and the second launches.
        push(rand_good_src(), 19'($urandom), 1'b0);
        push(rand_good_src(), 19'($urandom), 1'b0);
        wait_launch(ok);
        if (ok) begin
            check_launch(lc);
            w = 0;
            while (bus.err_timeout !== 1'b1 && w < 200) begin
                cycle();
                w++;
            end
            timeout_m = 1'b1;
            check("timeout_set", bus.err_timeout, timeout_m);
            // One LAUNCH cycle plus TIMEOUT wait cycles.
            check("timeout_latency", cyc - lc, TIMEOUT + 1);
            void'(exp_q.pop_front());
            check("timeout_no_count", bus.jobs_done, 8'(jobs_m));
        end
        serve($urandom_range(0, 30));
        check("timeout_sticky", bus.err_timeout, timeout_m);

        // Step 6: memory port ownership.
        push(rand_good_src(), 19'($urandom), 1'b0);
        wait_launch(ok);
        if (ok) begin
            check_launch(lc);
            ca = 10'($urandom); cd = 19'($urandom);
            aa = 10'($urandom); ad = 19'($urandom); aw = 1'($urandom);
            bus.cpu_mem_req   = 1'b1;
            bus.cpu_mem_write = 1'b1;
            bus.cpu_mem_addr  = ca;
            bus.cpu_mem_wdata = cd;
            bus.acc_mem_addr  = aa;
            bus.acc_mem_write = aw;
            bus.acc_mem_wdata = ad;
            #1;
            check("wait_cpu_stall", bus.cpu_stall, 1'b1);
            check("wait_mem_write", bus.mem_write, aw);
            check("wait_mem_addr", bus.mem_addr, aa);
            check("wait_mem_wdata", bus.mem_wdata, ad);
            bus.acc_done = 1'b1;
            cycle();
            bus.acc_done = 1'b0;
            retire_model();
            cycle();
            check_after_retire();
            check("idle_cpu_stall", bus.cpu_stall, 1'b0);
            check("idle_mem_write", bus.mem_write, 1'b1);
            check("idle_mem_addr", bus.mem_addr, ca);
            check("idle_mem_wdata", bus.mem_wdata, cd);
            bus.cpu_mem_req   = 1'b0;
            bus.cpu_mem_write = 1'b0;
            bus.acc_mem_write = 1'b0;
        end

        // Step 7: reset in the middle of a job with two more queued.
        for (int i = 0; i < 3; i++) push(rand_good_src(), 19'($urandom), 1'b0);
        wait_launch(ok);
        if (ok) check_launch(lc);
        repeat (5) cycle();
        rst = 1'b1;
        cycle();
        exp_q.delete();
        jobs_m    = 0;
        badtag_m  = 1'b0;
        timeout_m = 1'b0;
        check_reset_outputs("midjob_rst");
        rst = 1'b0;
        s0 = start_cnt;
        repeat (20) cycle();
        check("rst_no_relaunch", start_cnt - s0, 0);
        check("rst_idle_busy", bus.busy, exp_q.size() != 0);
        check("rst_jobs_done", bus.jobs_done, 8'(jobs_m));

        check("start_single_cycle", dbl_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
